// File: rtl/hex_display_bank.sv
// Multi-digit active-low seven-segment driver: latches a hex value on load and rewrites one digit per cycle, MSB first.
// Optional per-digit blinking is compiled in with HEX_DISPLAY_BLINK_EN.
module hex_display_bank #(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned NUM_SEGMENTS = 8,
    parameter int unsigned BLINK_DIV    = 25_000_000
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic [4*NUM_DIGITS-1:0]            value,
    input  logic [NUM_DIGITS-1:0]              dp_mask,
    input  logic                               blank_lz,
    input  logic                               load,
    input  logic [NUM_DIGITS-1:0]              blink_mask,
    output logic                               ready,
    output logic                               done,
    output logic [NUM_SEGMENTS*NUM_DIGITS-1:0] SS
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [VAL_W-1:0]        value_q, value_next;
    logic [NUM_DIGITS-1:0]   dp_q, dp_next;
    logic                    blz_q, blz_next;
    logic                    seen_nz, seen_nz_next;
    logic                    ready_next, done_next;
    logic                    seg_we;
    logic [7:0]              seg_wdata;
    logic [3:0]              nib;
    logic                    blank;
    logic [7:0]              seg_reg [NUM_DIGITS];

    // Segment patterns {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hex_lut(input logic [3:0] n);
        case (n)
            4'h0: hex_lut = 7'b1000000;
            4'h1: hex_lut = 7'b1111001;
            4'h2: hex_lut = 7'b0100100;
            4'h3: hex_lut = 7'b0110000;
            4'h4: hex_lut = 7'b0011001;
            4'h5: hex_lut = 7'b0010010;
            4'h6: hex_lut = 7'b0000010;
            4'h7: hex_lut = 7'b1111000;
            4'h8: hex_lut = 7'b0000000;
            4'h9: hex_lut = 7'b0010000;
            4'hA: hex_lut = 7'b0001000;
            4'hB: hex_lut = 7'b0000011;
            4'hC: hex_lut = 7'b1000110;
            4'hD: hex_lut = 7'b0100001;
            4'hE: hex_lut = 7'b0000110;
            default: hex_lut = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            idx     <= IDX_W'(NUM_DIGITS - 1);
            value_q <= '0;
            dp_q    <= '0;
            blz_q   <= 1'b0;
            seen_nz <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            value_q <= value_next;
            dp_q    <= dp_next;
            blz_q   <= blz_next;
            seen_nz <= seen_nz_next;
            ready   <= ready_next;
            done    <= done_next;
        end
    end

    // Next-state and scan datapath; seen_nz suppresses blanking once a nonzero digit was emitted.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        value_next   = value_q;
        dp_next      = dp_q;
        blz_next     = blz_q;
        seen_nz_next = seen_nz;
        ready_next   = 1'b0;
        done_next    = 1'b0;
        seg_we       = 1'b0;
        seg_wdata    = 8'hFF;
        nib          = value_q[4*idx +: 4];
        blank        = 1'b0;
        case (state)
            IDLE: begin
                ready_next = 1'b1;
                if (load) begin
                    value_next   = value;
                    dp_next      = dp_mask;
                    blz_next     = blank_lz;
                    idx_next     = IDX_W'(NUM_DIGITS - 1);
                    seen_nz_next = 1'b0;
                    state_next   = SCAN;
                    ready_next   = 1'b0;
                end
            end
            SCAN: begin
                seg_we = 1'b1;
                blank  = blz_q && (nib == 4'h0) && !seen_nz && (idx != '0);
                if (nib != 4'h0) begin
                    seen_nz_next = 1'b1;
                end
                seg_wdata = {~dp_q[idx], blank ? 7'h7F : hex_lut(nib)};
                if (idx == '0) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx - IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_reg[i] <= 8'hFF;
            end
        end else if (seg_we) begin
            seg_reg[idx] <= seg_wdata;
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_DIV + 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             phase;

    // Free-running blink timebase, independent of the scan.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
        assign SS[NUM_SEGMENTS*g +: NUM_SEGMENTS] = seg_reg[g] | {8{phase & blink_mask[g]}};
    end
`else
    wire unused_blink = ^{blink_mask, 32'(BLINK_DIV)};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
        assign SS[NUM_SEGMENTS*g +: NUM_SEGMENTS] = seg_reg[g];
    end
`endif

endmodule
